serial_word_tx: RTL and testbench
=================================

// Module: serial_word_tx
// PURPOSE
//   Parallel-to-serial word transmitter. Loads a WIDTH-bit word and shifts it out one bit per bit period.
//   Each bit comes with a one-cycle shift strobe that drives the serial-load input of a loadable shift counter.
//   DIR=0 sends MSB first, for a receiver that shifts left: Q <= {Q[W-2:0], SO}.
//   DIR=1 sends LSB first, for a receiver that shifts right: Q <= {SO, Q[W-1:1]}.
//   In both modes the receiver holds the original word after WIDTH strobes.
// PARAMETERS
//   WIDTH  4  word width in bits; legal range >= 2
//   DIV    1  clock cycles per bit period; legal range >= 1
// PORTS
//   C     in   1      clock; all state changes on posedge C
//   R     in   1      reset; asynchronous, active-high
//   D     in   WIDTH  parallel word; sampled only on the accept edge
//   L     in   1      load/start request; accepted when L=1, BUSY=0, A=0
//   DIR   in   1      bit order: 0 = MSB first, 1 = LSB first; sampled on the accept edge
//   A     in   1      synchronous abort
//   SO    out  1      serial data out
//   SE    out  1      shift strobe; receiver shifts on the posedge where SE=1
//   BUSY  out  1      high from the accept edge until the transfer finishes
//   DONE  out  1      one-cycle pulse after the last bit has been strobed
// BEHAVIOUR
//   Reset: R=1 forces state IDLE, regardless of C.
//     SO=0, SE=0, BUSY=0, DONE=0; shift register, bit counter and divider counter all cleared.
//     R mid-transfer aborts immediately; no DONE is produced.
//   Registers and outputs: all outputs are registered.
//     Shift register is WIDTH bits. Bit counter is clog2(WIDTH+1) bits. Divider counter is clog2(DIV) bits, min 1.
//   States: IDLE, SHIFT, DONE.
//   IDLE
//     BUSY=0, SE=0, SO=0, DONE=0.
//     Accept edge (L=1, A=0): latch D and DIR; clear bit counter and divider; go to SHIFT.
//     From the next cycle: BUSY=1, SO = D[WIDTH-1] if DIR=0, else D[0].
//   SHIFT
//     SO holds the current bit for exactly DIV cycles.
//     SE=1 during the last cycle of each bit period (divider == DIV-1); otherwise SE=0.
//     DIV=1 gives SE=1 on every SHIFT cycle.
//     On each SE edge: shift the register toward the output end, increment the bit counter, clear the divider.
//     SO presents the next bit in the following cycle.
//     After the WIDTH-th SE edge: go to DONE.
//   DONE
//     DONE=1 and BUSY=1 for exactly one cycle; SE=0, SO=0. Next edge goes to IDLE.
//   Latency
//     Accept edge to first SO bit: 1 cycle.
//     BUSY high for WIDTH*DIV+1 cycles. Exactly WIDTH SE pulses per transfer.
//   Boundary cases
//     L while BUSY=1, including the DONE cycle: ignored; D and DIR are not sampled.
//     L in the first cycle with BUSY=0: accepted, so back-to-back transfers are separated by a single IDLE cycle.
//     A=1 in SHIFT or DONE: next edge goes to IDLE with all outputs 0; no DONE pulse and no further SE.
//       A on the same edge as the last SE: the strobe in that cycle stands, DONE is suppressed.
//     A=1 together with L=1 in IDLE: A wins; the request is not accepted.
//     Changes on D or DIR during SHIFT have no effect on the word in flight.
// TESTING
//   1. WIDTH=4, DIV=1, DIR=0, D=4'b1011, L pulse
//      -> SO=1,0,1,1 on cycles 1..4 with SE=1 on each; DONE on cycle 5; BUSY low on cycle 6.
//      -> Left-shift loopback register holds 4'b1011.
//   2. WIDTH=4, DIV=1, DIR=1, D=4'b1011
//      -> SO=1,1,0,1; right-shift loopback register ends at 4'b1011.
//   3. DIV=3, D=4'b0110, DIR=0
//      -> each bit held 3 cycles; SE on cycles 3,6,9,12 only; BUSY high for 13 cycles; one DONE pulse.
//   4. During transfer of 4'hA: L with D=4'h5 mid-SHIFT, and again on the DONE cycle -> both ignored, 4'hA delivered.
//      -> L held through the first BUSY=0 cycle -> 4'h5 accepted, SO=0 on the first cycle.
//   5. A=1 after the 2nd SE -> next cycle BUSY=0, SO=0, SE=0, no DONE.
//      -> A=1 and L=1 together in IDLE -> BUSY stays 0.
//   6. R asserted asynchronously between clock edges mid-SHIFT -> outputs 0 immediately.
//      -> After R is released, a new L is accepted normally and the transfer completes.

Source files
------------

// File: rtl/serial_word_tx_if.sv
// Handshake and serial-side signals of the word transmitter.
// master drives the word and controls; slave is the transmitter itself.
interface serial_word_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic             l;
  logic             dir;
  logic             a;
  logic             so;
  logic             se;
  logic             busy;
  logic             done;

  modport master (output d, l, dir, a, input so, se, busy, done);
  modport slave  (input d, l, dir, a, output so, se, busy, done);
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: shifts a latched word out MSB- or LSB-first,
// one bit per DIV-cycle period, with a shift strobe on the last cycle of each period.
module serial_word_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_word_tx_if.slave bus
);
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic           SE_EVERY = (DIV == 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shifted;
  logic [BCW-1:0]   bitcnt_reg;
  logic [DCW-1:0]   divcnt_reg;
  logic             dir_reg;
  logic             so_reg;
  logic             se_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             next_bit;

  // Register moved one place toward the output end; the vacated bit fills with 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lo
        assign shifted[gi] = dir_reg ? shreg_reg[1] : 1'b0;
      end else if (gi == WIDTH - 1) begin : g_hi
        assign shifted[gi] = dir_reg ? 1'b0 : shreg_reg[gi-1];
      end else begin : g_mid
        assign shifted[gi] = dir_reg ? shreg_reg[gi+1] : shreg_reg[gi-1];
      end
    end
  endgenerate

  assign next_bit = dir_reg ? shifted[0] : shifted[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      divcnt_reg <= '0;
      dir_reg    <= 1'b0;
      so_reg     <= 1'b0;
      se_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.l && !bus.a) begin
            state_reg  <= ST_SHIFT;
            shreg_reg  <= bus.d;
            dir_reg    <= bus.dir;
            bitcnt_reg <= '0;
            divcnt_reg <= '0;
            busy_reg   <= 1'b1;
            so_reg     <= bus.dir ? bus.d[0] : bus.d[WIDTH-1];
            se_reg     <= SE_EVERY;
          end
        end
        ST_SHIFT: begin
          if (bus.a) begin
            state_reg <= ST_IDLE;
            so_reg    <= 1'b0;
            se_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end else if (se_reg) begin
            // se_reg high means this cycle closes a bit period: the receiver shifts now.
            shreg_reg  <= shifted;
            bitcnt_reg <= bitcnt_reg + BCW'(1);
            divcnt_reg <= '0;
            if (bitcnt_reg == BIT_LAST) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              so_reg    <= 1'b0;
              se_reg    <= 1'b0;
            end else begin
              so_reg <= next_bit;
              se_reg <= SE_EVERY;
            end
          end else begin
            divcnt_reg <= divcnt_reg + DCW'(1);
            se_reg     <= ((divcnt_reg + DCW'(1)) == DIV_LAST);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          so_reg    <= 1'b0;
          se_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          so_reg    <= 1'b0;
          se_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.so   = so_reg;
  assign bus.se   = se_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (DIV=1 and DIV=3) exercised one at a time,
// expected words queued at accept and checked by a monitor on each DONE pulse.
module tb_serial_word_tx;
  typedef struct packed {
    logic [3:0] w;
    logic       dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, sel;
  logic [3:0] d;
  logic       l, dir, a;
  int         checks = 0;
  int         failures = 0;
  exp_t       q[$];

  always #5 clk = ~clk;

  serial_word_tx_if #(.WIDTH(4)) ifa ();
  serial_word_tx_if #(.WIDTH(4)) ifb ();

  assign ifa.d = d;  assign ifa.l = l;  assign ifa.dir = dir;  assign ifa.a = a;
  assign ifb.d = d;  assign ifb.l = l;  assign ifb.dir = dir;  assign ifb.a = a;

  serial_word_tx #(.WIDTH(4), .DIV(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  serial_word_tx #(.WIDTH(4), .DIV(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  // The idle instance is held in reset, so the monitor follows the selected one.
  wire so_m    = sel ? ifb.so   : ifa.so;
  wire se_m    = sel ? ifb.se   : ifa.se;
  wire busy_m  = sel ? ifb.busy : ifa.busy;
  wire done_m  = sel ? ifb.done : ifa.done;
  wire rst_cur = sel ? rst_b    : rst_a;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: records the SO/SE waveform of each transfer and compares it with
  // the waveform the queued word must produce, plus a loopback receiver.
  int          hist_n = 0;
  logic [31:0] so_w, se_w, exp_so, exp_se;
  logic [3:0]  rx_l, rx_r;
  bit          after_done = 0;
  exp_t        e_m;
  int          div_cur;

  always @(negedge clk) begin
    div_cur = sel ? 3 : 1;
    if (rst_cur) begin
      hist_n = 0; so_w = '0; se_w = '0; rx_l = '0; rx_r = '0; after_done = 0;
    end else begin
      if (after_done) chk("done_single", !busy_m && !done_m, 32'({busy_m, done_m}), 0);
      after_done = 0;
      if (!busy_m) begin
        chk("idle_outputs", !so_m && !se_m && !done_m, 32'({so_m, se_m, done_m}), 0);
        hist_n = 0; so_w = '0; se_w = '0;
      end else begin
        if (hist_n < 32) begin
          so_w[hist_n] = so_m;
          se_w[hist_n] = se_m;
        end
        hist_n++;
        if (se_m) begin
          rx_l = {rx_l[2:0], so_m};
          rx_r = {so_m, rx_r[3:1]};
        end
        if (done_m) begin
          after_done = 1;
          if (q.size() == 0) begin
            chk("unexpected_done", 0, 1, 0);
          end else begin
            e_m = q.pop_front();
            exp_so = '0; exp_se = '0;
            for (int k = 0; k < 4; k++)
              for (int j = 0; j < div_cur; j++) begin
                exp_so[k*div_cur+j] = e_m.dir ? e_m.w[k] : e_m.w[3-k];
                exp_se[k*div_cur+j] = (j == div_cur - 1);
              end
            chk("busy_len", hist_n == 4*div_cur+1, 32'(hist_n), 32'(4*div_cur+1));
            chk("so_wave", so_w == exp_so, so_w, exp_so);
            chk("se_wave", se_w == exp_se, se_w, exp_se);
            chk("rx_word", (e_m.dir ? rx_r : rx_l) == e_m.w,
                32'(e_m.dir ? rx_r : rx_l), 32'(e_m.w));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_m && n < 200) begin tick(); n++; end
    if (busy_m) chk("idle_timeout", 0, 1, 0);
  endtask

  task automatic start(input logic [3:0] w, input logic dr, input bit push);
    exp_t e;
    tick();
    wait_idle();
    d = w; dir = dr; l = 1'b1;
    e.w = w; e.dir = dr;
    if (push) q.push_back(e);
    tick();
    l = 1'b0; d = 4'($urandom); dir = 1'($urandom);
  endtask

  // Abort in the cycle that shows the k-th strobe; the next cycle must be idle.
  task automatic abort_at_se(input int k, input logic [3:0] w);
    int cnt = 0;
    start(w, 1'b0, 1'b0);
    for (int n = 0; n < 100 && cnt < k; n++) begin
      if (n > 0) tick();
      if (se_m) cnt++;
    end
    if (cnt < k) chk("abort_se_timeout", 0, 32'(cnt), 32'(k));
    a = 1'b1;
    tick();
    a = 1'b0;
    chk("abort_idle", !busy_m && !so_m && !se_m && !done_m, 32'({busy_m, so_m, se_m, done_m}), 0);
    repeat (6) tick();
  endtask

  task automatic rand_run(input int cycles);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      tick();
      l = ($urandom % 4 == 0);
      a = ($urandom % 40 == 0);
      d = 4'($urandom); dir = 1'($urandom);
      if (a && busy_m) q.delete();
      if (l && !a && !busy_m) begin
        e.w = d; e.dir = dir;
        q.push_back(e);
      end
    end
    tick();
    l = 1'b0; a = 1'b0;
    wait_idle();
  endtask

  initial begin
    exp_t e;
    int   n;
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    d = '0; l = 1'b0; dir = 1'b0; a = 1'b0;
    repeat (3) tick();
    chk("reset_a", {ifa.so, ifa.se, ifa.busy, ifa.done} == 4'b0, 32'({ifa.so, ifa.se, ifa.busy, ifa.done}), 0);
    chk("reset_b", {ifb.so, ifb.se, ifb.busy, ifb.done} == 4'b0, 32'({ifb.so, ifb.se, ifb.busy, ifb.done}), 0);
    rst_a = 1'b0;

    // DIV=1: MSB first, LSB first
    start(4'b1011, 1'b0, 1'b1);
    wait_idle();
    start(4'b1011, 1'b1, 1'b1);
    wait_idle();

    // L during SHIFT and DONE ignored; held L is taken on the first idle cycle
    start(4'hA, 1'b0, 1'b1);
    tick();
    l = 1'b1; d = 4'h5; dir = 1'b0;
    n = 0;
    while (busy_m && n < 50) begin tick(); n++; end
    if (busy_m) chk("hold_l_timeout", 0, 1, 0);
    e.w = 4'h5; e.dir = 1'b0;
    q.push_back(e);
    tick();
    l = 1'b0;
    wait_idle();

    rand_run(300);

    // switch to the DIV=3 instance
    tick();
    rst_a = 1'b1; sel = 1'b1; rst_b = 1'b0;
    tick();
    start(4'b0110, 1'b0, 1'b1);
    wait_idle();

    abort_at_se(2, 4'b1101);
    abort_at_se(4, 4'b0111);

    // abort and load together in IDLE: abort wins
    tick();
    a = 1'b1; l = 1'b1; d = 4'h9;
    tick();
    a = 1'b0; l = 1'b0;
    chk("abort_wins", !busy_m, 32'(busy_m), 0);

    // asynchronous reset between edges mid-transfer
    start(4'b1110, 1'b1, 1'b0);
    repeat (4) tick();
    #1 rst_b = 1'b1;
    #1 chk("async_reset", {ifb.so, ifb.se, ifb.busy, ifb.done} == 4'b0,
           32'({ifb.so, ifb.se, ifb.busy, ifb.done}), 0);
    tick();
    rst_b = 1'b0;
    start(4'b1001, 1'b1, 1'b1);
    wait_idle();

    rand_run(400);

    repeat (3) tick();
    chk("queue_drained", q.size() == 0, 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
